freq_meter: RTL and testbench
=============================

# freq_meter

Gated frequency counter for the lab clock tree. Counts rising edges of an asynchronous slow input `sig_in` over a fixed window of `GATE_CYCLES` ticks of the 1 MHz system clock, then reports the count. The default window is 1 s, so the count reads directly in Hz. It checks the output of the clock divider and measures external slow signals.

## Interface
- `GATE_CYCLES`, default 1000000: measurement window length in `clk` cycles (1 s at 1 MHz).
- `CW`, default 20: width of the edge count. Max detectable rate is clk/2, so 500000 fits in 20 bits.
- `GW`, default 20: width of the window counter. Must satisfy 2^GW >= GATE_CYCLES.
- `clk` input 1: system clock, 1 MHz, rising-edge only.
- `rst` input 1: reset, synchronous, active-high.
- `sig_in` input 1: asynchronous signal to be measured.
- `start` input 1: single-cycle request to begin a measurement.
- `busy` output 1: high while a window is open (state GATE).
- `valid` output 1: one-cycle pulse when `count_out` has been updated.
- `count_out` output CW: rising edges counted in the last completed window. Held until the next completion.
- `ovf` output 1: the last window's count saturated. Updated together with `count_out`.

## Operation
- Input path: `sig_in` passes through a 2-flop synchronizer, then a previous-sample flop. A rising edge is detected when the synchronized value is 1 and the previous sample is 0. All three flops reset to 0.
- FSM states:
  - IDLE (reset state): `start`=1 moves to GATE. The window counter and edge counter clear to 0.
  - GATE: the window counter increments every cycle. When it equals GATE_CYCLES-1, the FSM moves to DONE.
  - DONE: lasts exactly 1 cycle, then returns to IDLE.
- Edge counting: an edge is counted only if it is detected in a cycle where state is GATE, including the first and last GATE cycles.
- Saturation: the edge counter saturates at 2^CW-1. Any further detected edge in the same window sets an internal overflow bit.
- Completion: on entry to DONE, `count_out` and `ovf` are loaded from the counter and the overflow bit, and `valid`=1 for that single cycle.
- `start` is ignored in GATE and in DONE; there is no queueing. `start` in IDLE is always accepted.
- Reset mid-window: `rst` returns the FSM to IDLE and clears all counters and outputs. No `valid` is produced for the aborted window.
- A `sig_in` that is high across reset release produces one detected edge 2–3 cycles later. It is counted only if GATE is already active, which cannot happen because the FSM needs at least one IDLE cycle for `start`.

## Timing
- Reset values: `busy`=0, `valid`=0, `count_out`=0, `ovf`=0. Optional `period_out`=0.
- `start` sampled high in cycle N → `busy`=1 from cycle N+1 through N+GATE_CYCLES (exactly GATE_CYCLES cycles).
- `valid`=1 in cycle N+GATE_CYCLES+1; `busy`=0 in that cycle.
- The earliest accepted restart is `start` in cycle N+GATE_CYCLES+2 (IDLE).
- Input latency: a `sig_in` rising edge between clk edges k-1 and k is detected in cycle k+2.
- The window aligns to detected edges, not to raw `sig_in`.
- A window length that is an integer multiple of the input period yields an exact count, independent of phase.

## Configuration
- `FREQ_METER_PERIOD_EN` defined:
  - Adds output `period_out` [GW-1:0], the clk cycles between the last two detected edges inside the window.
  - `period_out` loads with `count_out` on DONE.
  - It is 0 if fewer than 2 edges were counted.
  - A free-running cycle counter clears on each counted edge and saturates at 2^GW-1.
- `FREQ_METER_PERIOD_EN` undefined: the port and logic are absent, and all other behaviour is identical.

## Test plan
- Exact count: GATE_CYCLES=1000; `sig_in` period 10 cycles at 50% duty, arbitrary phase; pulse `start` → `valid` 1001 cycles later, `count_out`=100, `ovf`=0.
- No edges: `sig_in` held 1 from before reset; `start` → `count_out`=0, `ovf`=0.
- Saturation: CW=4, GATE_CYCLES=100, `sig_in` period 4 (25 edges) → `count_out`=15, `ovf`=1. The next window with period 20 (5 edges) → `count_out`=5, `ovf`=0.
- Reset mid-window: `rst` pulsed at window cycle 500 → `busy`=0 and `count_out`=0 the next cycle, with no `valid`. A new `start` gives a full fresh window with `count_out`=100.
- Start while busy: second `start` 300 cycles into the window → exactly one `valid`, at cycle N+1001, and `busy` drops after it.
- `FREQ_METER_PERIOD_EN`: period-10 input → `period_out`=10. A single edge in the window (`sig_in` raised once) → `count_out`=1, `period_out`=0.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter.
// Counts synchronized rising edges of sig_in over a window of GATE_CYCLES clk
// cycles and reports the count (saturating at 2^CW-1, with ovf flag).
// Optional feature macro: FREQ_METER_PERIOD_EN adds period_out, the clk cycles
// between the last two counted edges of the window.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 1000000,
    parameter int unsigned CW          = 20,
    parameter int unsigned GW          = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    input  logic          start,
    output logic          busy,
    output logic          valid,
    output logic [CW-1:0] count_out,
    output logic          ovf
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [GW-1:0] period_out
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [GW-1:0] WIN_LAST = GW'(GATE_CYCLES - 1);

    state_t        state_q, state_d;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;

    logic          edge_det;
    logic          counted_edge;
    logic          win_last;

    logic [GW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_int_q, ovf_int_d;
    logic [CW-1:0] count_out_q, count_out_d;
    logic          ovf_out_q, ovf_out_d;

`ifdef FREQ_METER_PERIOD_EN
    logic [GW-1:0] per_cnt_q, per_cnt_d;
    logic [GW-1:0] per_last_q, per_last_d;
    logic [GW-1:0] period_out_q, period_out_d;
    logic [GW-1:0] per_span;
`endif

    // Input synchronizer, previous-sample flop and edge qualification
    always_comb begin
        sync1_d      = sig_in;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        edge_det     = sync2_q & ~prev_q;
        counted_edge = edge_det && (state_q == GATE);
        win_last     = (state_q == GATE) && (win_q == WIN_LAST);
    end

    // FSM state register and all datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            win_q        <= '0;
            cnt_q        <= '0;
            ovf_int_q    <= 1'b0;
            count_out_q  <= '0;
            ovf_out_q    <= 1'b0;
`ifdef FREQ_METER_PERIOD_EN
            per_cnt_q    <= '0;
            per_last_q   <= '0;
            period_out_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            ovf_int_q    <= ovf_int_d;
            count_out_q  <= count_out_d;
            ovf_out_q    <= ovf_out_d;
`ifdef FREQ_METER_PERIOD_EN
            per_cnt_q    <= per_cnt_d;
            per_last_q   <= per_last_d;
            period_out_q <= period_out_d;
`endif
        end
    end

    // Next-state logic: IDLE -> GATE on start, GATE -> DONE at window end, DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = GATE;
            GATE:    if (win_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window counter, saturating edge counter and result capture
    always_comb begin
        win_d       = win_q;
        cnt_d       = cnt_q;
        ovf_int_d   = ovf_int_q;
        count_out_d = count_out_q;
        ovf_out_d   = ovf_out_q;
        case (state_q)
            IDLE: begin
                win_d     = '0;
                cnt_d     = '0;
                ovf_int_d = 1'b0;
            end
            GATE: begin
                win_d = win_q + GW'(1);
                if (counted_edge) begin
                    if (cnt_q == '1) begin
                        ovf_int_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
        // Capture uses the next-cycle values so an edge in the last GATE cycle is included
        if (win_last) begin
            count_out_d = cnt_d;
            ovf_out_d   = ovf_int_d;
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    // Edge-to-edge interval tracking; only edges after the first in a window update the period
    always_comb begin
        per_span     = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + GW'(1);
        per_cnt_d    = per_span;
        per_last_d   = per_last_q;
        period_out_d = period_out_q;
        if (state_q == IDLE) begin
            per_last_d = '0;
        end
        if (counted_edge) begin
            per_cnt_d = '0;
            if ((cnt_q != '0) || ovf_int_q) begin
                per_last_d = per_span;
            end
        end
        if (win_last) begin
            period_out_d = per_last_d;
        end
    end
`endif

    // Output decode from state and result registers
    always_comb begin
        busy      = (state_q == GATE);
        valid     = (state_q == DONE);
        count_out = count_out_q;
        ovf       = ovf_out_q;
`ifdef FREQ_METER_PERIOD_EN
        period_out = period_out_q;
`endif
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: main instance (1000-cycle window) and a
// small saturating instance (CW=4, 100-cycle window). Period checks are built
// only when FREQ_METER_PERIOD_EN is defined.
module tb_freq_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sig = 1'b0;
    logic       busy, valid, ovf;
    logic [19:0] count_out;
`ifdef FREQ_METER_PERIOD_EN
    logic [9:0] period_out;
`endif

    logic       start_s = 1'b0;
    logic       sig_s = 1'b0;
    logic       busy_s, valid_s, ovf_s;
    logic [3:0] count_s;
`ifdef FREQ_METER_PERIOD_EN
    logic [6:0] period_s;
`endif

    int tests = 0;
    int fails = 0;

    int per_m = 0;
    int ph_m = 3;
    logic hold_m = 1'b0;
    int per_s = 0;
    int ph_s = 1;

    freq_meter #(.GATE_CYCLES(1000), .CW(20), .GW(10)) dut (
        .clk(clk), .rst(rst), .sig_in(sig), .start(start),
        .busy(busy), .valid(valid), .count_out(count_out), .ovf(ovf)
`ifdef FREQ_METER_PERIOD_EN
        , .period_out(period_out)
`endif
    );

    freq_meter #(.GATE_CYCLES(100), .CW(4), .GW(7)) dut_sat (
        .clk(clk), .rst(rst), .sig_in(sig_s), .start(start_s),
        .busy(busy_s), .valid(valid_s), .count_out(count_s), .ovf(ovf_s)
`ifdef FREQ_METER_PERIOD_EN
        , .period_out(period_s)
`endif
    );

    // Stimulus generator: periodic 50% duty waveforms or a held level
    initial begin
        forever begin
            @(negedge clk);
            if (per_m != 0) begin
                ph_m = (ph_m + 1) % per_m;
                sig  = (ph_m < per_m / 2);
            end else begin
                sig = hold_m;
            end
            if (per_s != 0) begin
                ph_s  = (ph_s + 1) % per_s;
                sig_s = (ph_s < per_s / 2);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start_s();
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    // Returns cycles since start (start cycle = 0), or the limit on timeout
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!valid && cyc < 1500) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_valid_s(output int cyc);
        cyc = 1;
        while (!valid_s && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        tests++; if (count_out !== 20'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        tests++; if (count_s !== 4'd0 || ovf_s !== 1'b0 || busy_s !== 1'b0) begin
            fails++; $display("FAIL reset_sat: got count=%0d ovf=%b busy=%b expected 0/0/0", count_s, ovf_s, busy_s);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_edges();
        int cyc;
        per_m  = 0;
        hold_m = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        pulse_start();
        wait_valid(cyc);
        tests++; if (cyc !== 1001) begin fails++; $display("FAIL no_edges_latency: got %0d expected 1001", cyc); end
        tests++; if (count_out !== 20'd0) begin fails++; $display("FAIL no_edges_count: got %0d expected 0", count_out); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL no_edges_ovf: got %b expected 0", ovf); end
        @(negedge clk);
    endtask

    task automatic test_exact_count();
        int cyc;
        per_m = 10;
        repeat (20) @(negedge clk);
        pulse_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL exact_busy_first: got %b expected 1", busy); end
        wait_valid(cyc);
        tests++; if (cyc !== 1001) begin fails++; $display("FAIL exact_latency: got %0d expected 1001", cyc); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL exact_busy_at_valid: got %b expected 0", busy); end
        tests++; if (count_out !== 20'd100) begin fails++; $display("FAIL exact_count: got %0d expected 100", count_out); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL exact_ovf: got %b expected 0", ovf); end
`ifdef FREQ_METER_PERIOD_EN
        tests++; if (period_out !== 10'd10) begin fails++; $display("FAIL exact_period: got %0d expected 10", period_out); end
`endif
        @(negedge clk);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL exact_valid_one_cycle: got %b expected 0", valid); end
        tests++; if (count_out !== 20'd100) begin fails++; $display("FAIL exact_count_held: got %0d expected 100", count_out); end
    endtask

    task automatic test_reset_mid_window();
        int cyc;
        int nval = 0;
        pulse_start();
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        tests++; if (count_out !== 20'd0) begin fails++; $display("FAIL rstmid_count: got %0d expected 0", count_out); end
        for (int i = 0; i < 700; i++) begin
            if (valid) nval++;
            @(negedge clk);
        end
        tests++; if (nval !== 0) begin fails++; $display("FAIL rstmid_no_valid: got %0d valid pulses expected 0", nval); end
        pulse_start();
        wait_valid(cyc);
        tests++; if (cyc !== 1001) begin fails++; $display("FAIL rstmid_fresh_latency: got %0d expected 1001", cyc); end
        tests++; if (count_out !== 20'd100) begin fails++; $display("FAIL rstmid_fresh_count: got %0d expected 100", count_out); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int c;
        int nval = 0;
        int vcyc = -1;
        logic b1000 = 1'b0;
        logic b1002 = 1'b1;
        pulse_start();
        repeat (299) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 301;
        while (c < 1200) begin
            if (valid) begin
                nval++;
                if (vcyc < 0) vcyc = c;
            end
            if (c == 1000) b1000 = busy;
            if (c == 1002) b1002 = busy;
            @(negedge clk);
            c++;
        end
        tests++; if (nval !== 1) begin fails++; $display("FAIL busy_start_nvalid: got %0d expected 1", nval); end
        tests++; if (vcyc !== 1001) begin fails++; $display("FAIL busy_start_valid_cycle: got %0d expected 1001", vcyc); end
        tests++; if (b1000 !== 1'b1) begin fails++; $display("FAIL busy_start_busy_last: got %b expected 1", b1000); end
        tests++; if (b1002 !== 1'b0) begin fails++; $display("FAIL busy_start_busy_after: got %b expected 0", b1002); end
    endtask

    task automatic test_saturation();
        int cyc;
        per_s = 4;
        repeat (10) @(negedge clk);
        pulse_start_s();
        wait_valid_s(cyc);
        tests++; if (cyc !== 101) begin fails++; $display("FAIL sat_latency: got %0d expected 101", cyc); end
        tests++; if (count_s !== 4'd15) begin fails++; $display("FAIL sat_count: got %0d expected 15", count_s); end
        tests++; if (ovf_s !== 1'b1) begin fails++; $display("FAIL sat_ovf: got %b expected 1", ovf_s); end
        per_s = 20;
        repeat (30) @(negedge clk);
        pulse_start_s();
        wait_valid_s(cyc);
        tests++; if (count_s !== 4'd5) begin fails++; $display("FAIL sat_next_count: got %0d expected 5", count_s); end
        tests++; if (ovf_s !== 1'b0) begin fails++; $display("FAIL sat_next_ovf: got %b expected 0", ovf_s); end
        @(negedge clk);
    endtask

`ifdef FREQ_METER_PERIOD_EN
    task automatic test_period_single_edge();
        int cyc;
        per_m  = 0;
        hold_m = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (100) @(negedge clk);
        hold_m = 1'b1;
        wait_valid(cyc);
        tests++; if (count_out !== 20'd1) begin fails++; $display("FAIL single_edge_count: got %0d expected 1", count_out); end
        tests++; if (period_out !== 10'd0) begin fails++; $display("FAIL single_edge_period: got %0d expected 0", period_out); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_no_edges();
        test_exact_count();
        test_reset_mid_window();
        test_start_while_busy();
        test_saturation();
`ifdef FREQ_METER_PERIOD_EN
        test_period_single_edge();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
